// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage indices and the scoreboard entry layout for pipe_ctl.
// The entry fields are a fixed width that covers any practical stage index.
// Users zero-extend their SW-wide stage indices into these fields.
package pipe_pkg;

   localparam int unsigned IF_STG = 0;
   localparam int unsigned ID_STG = 1;
   localparam int unsigned EX_STG = 2;
   localparam int unsigned EC_STG = 3;
   localparam int unsigned WB_STG = 4;

   localparam int unsigned SB_IDX_W = 8;

   typedef struct packed {
      logic                valid;
      logic [SB_IDX_W-1:0] pos;   // stage currently holding the producer
      logic [SB_IDX_W-1:0] rdy;   // first stage whose output is bypassable
   } sb_entry_t;

endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register scoreboard that tracks in-flight results by stage.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   hold_i                per-stage hold; the instruction in stage s moves on when !hold_i[s]
//   iss_ok_i              ID instruction issues this cycle
//   iss_wreg_i/iss_rdy_i  destination register and its ready stage
//   flush_i/flush_stg_i   flush takes effect, killing stages 0..flush_stg_i
//   id_*                  ID read ports
//   id_hazard_o           ID read hits a pending entry (registered state only)
module hz_scoreboard
   import pipe_pkg::*;
#(
   parameter int unsigned STAGES = 5,
   parameter int unsigned ID_STG = 1,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned SW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] hold_i,
   input  logic              iss_ok_i,
   input  logic [REG_W-1:0]  iss_wreg_i,
   input  logic [SW-1:0]     iss_rdy_i,
   input  logic              flush_i,
   input  logic [SW-1:0]     flush_stg_i,
   input  logic              id_rs_ren_i,
   input  logic              id_rt_ren_i,
   input  logic [REG_W-1:0]  id_rs_i,
   input  logic [REG_W-1:0]  id_rt_i,
   output logic              id_hazard_o
);

   localparam int unsigned NREG = 1 << REG_W;
   localparam logic [SB_IDX_W-1:0] IssPos = SB_IDX_W'(ID_STG + 1);

   sb_entry_t           ent_q [NREG];
   sb_entry_t           ent_d [NREG];
   logic [SB_IDX_W-1:0] npos  [NREG];
   logic [SB_IDX_W-1:0] fk;
   logic [SB_IDX_W-1:0] irdy;

   assign fk   = SB_IDX_W'(flush_stg_i);
   assign irdy = SB_IDX_W'(iss_rdy_i);

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         ent_d[r] = ent_q[r];
         npos[r]  = ent_q[r].pos;
         // The producer leaves stage s only when that stage is not held; WB may step to STAGES.
         for (int s = 0; s < STAGES; s++) begin
            if (ent_q[r].pos == SB_IDX_W'(s) && !hold_i[s]) begin
               npos[r] = ent_q[r].pos + 1'b1;
            end
         end
         ent_d[r].pos = npos[r];
         if (!ent_q[r].valid || npos[r] >= ent_q[r].rdy ||
             (flush_i && ent_q[r].pos <= fk)) begin
            ent_d[r] = '0;
         end
         // A new issue overrides both the old entry and its clear.
         if (iss_ok_i && iss_wreg_i == REG_W'(r) && irdy > IssPos) begin
            ent_d[r] = '{valid: 1'b1, pos: IssPos, rdy: irdy};
         end
      end
      ent_d[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            ent_q[r] <= '0;
         end
      end else begin
         ent_q <= ent_d;
      end
   end

   assign id_hazard_o = (id_rs_ren_i && id_rs_i != '0 && ent_q[id_rs_i].valid) ||
                        (id_rt_ren_i && id_rt_i != '0 && ent_q[id_rt_i].valid);

endmodule

// File: rtl/pipe_ctl.sv
// pipe_ctl: stall/refresh controller for a STAGES-deep in-order pipeline.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   stg_busy                       per-stage busy
//   flush_req/flush_stg/flush_ack  flush request, oldest killed stage, flush taking effect
//   id_rs*/id_rt*                  ID source reads; id_hazard flags a scoreboard hit
//   iss_wen/iss_wreg/iss_rdy       ID destination write and its ready stage
//   inst_req/addr_ok/data_ok       fetch handshake; inst_drop marks stale responses
//   stall/refresh                  per-boundary hold and bubble-load controls
module pipe_ctl
   import pipe_pkg::*;
#(
   parameter int unsigned STAGES   = 5,
   parameter int unsigned ID_STG   = 1,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned MAX_IOUT = 3,
   parameter int unsigned SW       = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] stg_busy,
   input  logic              flush_req,
   input  logic [SW-1:0]     flush_stg,
   output logic              flush_ack,
   input  logic              id_rs_ren,
   input  logic              id_rt_ren,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              iss_wen,
   input  logic [REG_W-1:0]  iss_wreg,
   input  logic [SW-1:0]     iss_rdy,
   output logic              id_hazard,
   input  logic              inst_req,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   output logic              inst_drop,
   output logic [STAGES-2:0] stall,
   output logic [STAGES-2:0] refresh
);

   localparam int unsigned LastStg = STAGES - 1;
   localparam int unsigned CW      = $clog2(MAX_IOUT + 1);

   logic              flush_pend_q, flush_pend_d;
   logic [SW-1:0]     pend_stg_q, pend_stg_d;
   logic [CW-1:0]     out_cnt_q, out_cnt_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic              fl_act, fl_eff;
   logic [SW-1:0]     fl_k;
   logic [STAGES-1:0] eb_raw, hold_raw, eb, hold;
   logic              iss_ok, acc, dec;

   always_comb begin
      fl_act = flush_req | flush_pend_q;
      fl_k   = flush_stg;
      if (flush_pend_q && (!flush_req || pend_stg_q > flush_stg)) begin
         fl_k = pend_stg_q;
      end

      eb_raw         = stg_busy;
      eb_raw[ID_STG] = stg_busy[ID_STG] | id_hazard;
      hold_raw[LastStg] = eb_raw[LastStg];
      for (int j = int'(LastStg) - 1; j >= 0; j--) begin
         hold_raw[j] = eb_raw[j] | hold_raw[j+1];
      end

      // Masking only touches stages <= k, so the unmasked hold[k+1] is already final.
      fl_eff = 1'b0;
      if (fl_act) begin
         if (fl_k >= SW'(LastStg)) begin
            fl_eff = 1'b1;
         end else begin
            for (int j = 1; j <= int'(LastStg); j++) begin
               if (fl_k == SW'(j - 1)) fl_eff = !hold_raw[j];
            end
         end
      end

      for (int j = 0; j < STAGES; j++) begin
         eb[j] = eb_raw[j] & !(fl_eff && SW'(j) <= fl_k);
      end
      hold[LastStg] = eb[LastStg];
      for (int j = int'(LastStg) - 1; j >= 0; j--) begin
         hold[j] = eb[j] | hold[j+1];
      end

      for (int i = 0; i < STAGES - 1; i++) begin
         stall[i]   = hold[i+1];
         refresh[i] = !hold[i+1] & (hold[i] | (fl_eff && SW'(i) <= fl_k));
      end

      flush_pend_d = fl_act & !fl_eff;
      pend_stg_d   = pend_stg_q;
      if (fl_eff) begin
         pend_stg_d = '0;
      end else if (fl_act) begin
         pend_stg_d = fl_k;
      end
   end

   assign flush_ack = fl_eff;
   assign iss_ok    = iss_wen & !stall[ID_STG] & !refresh[ID_STG];

   // Fetch tracking: a saturated counter refuses further accepts.
   assign acc       = inst_req & inst_addr_ok & ((out_cnt_q != CW'(MAX_IOUT)) | inst_data_ok);
   assign dec       = inst_data_ok & (out_cnt_q != '0);
   assign out_cnt_d = out_cnt_q + CW'(acc) - CW'(dec);
   assign inst_drop = inst_data_ok & (drop_cnt_q != '0);

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (fl_eff) begin
         drop_cnt_d = out_cnt_d;
      end else if (inst_drop) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_pend_q <= 1'b0;
         pend_stg_q   <= '0;
         out_cnt_q    <= '0;
         drop_cnt_q   <= '0;
      end else begin
         flush_pend_q <= flush_pend_d;
         pend_stg_q   <= pend_stg_d;
         out_cnt_q    <= out_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   hz_scoreboard #(
      .STAGES (STAGES),
      .ID_STG (ID_STG),
      .REG_W  (REG_W),
      .SW     (SW)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .hold_i      (hold),
      .iss_ok_i    (iss_ok),
      .iss_wreg_i  (iss_wreg),
      .iss_rdy_i   (iss_rdy),
      .flush_i     (fl_eff),
      .flush_stg_i (fl_k),
      .id_rs_ren_i (id_rs_ren),
      .id_rt_ren_i (id_rt_ren),
      .id_rs_i     (id_rs),
      .id_rt_i     (id_rt),
      .id_hazard_o (id_hazard)
   );

endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl: directed-vector bench for pipe_ctl with hand-computed expectations.
module tb_pipe_ctl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] stg_busy;
   logic       flush_req;
   logic [2:0] flush_stg;
   logic       flush_ack;
   logic       id_rs_ren, id_rt_ren;
   logic [4:0] id_rs, id_rt;
   logic       iss_wen;
   logic [4:0] iss_wreg;
   logic [2:0] iss_rdy;
   logic       id_hazard;
   logic       inst_req, inst_addr_ok, inst_data_ok, inst_drop;
   logic [3:0] stall, refresh;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_ctl u_dut (
      .clk          (clk),
      .rst          (rst),
      .stg_busy     (stg_busy),
      .flush_req    (flush_req),
      .flush_stg    (flush_stg),
      .flush_ack    (flush_ack),
      .id_rs_ren    (id_rs_ren),
      .id_rt_ren    (id_rt_ren),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .iss_wen      (iss_wen),
      .iss_wreg     (iss_wreg),
      .iss_rdy      (iss_rdy),
      .id_hazard    (id_hazard),
      .inst_req     (inst_req),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_drop    (inst_drop),
      .stall        (stall),
      .refresh      (refresh)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      stg_busy     = '0;
      flush_req    = 1'b0;
      flush_stg    = '0;
      id_rs_ren    = 1'b0;
      id_rt_ren    = 1'b0;
      id_rs        = '0;
      id_rt        = '0;
      iss_wen      = 1'b0;
      iss_wreg     = '0;
      iss_rdy      = '0;
      inst_req     = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
   endtask

   // Drive a fresh cycle shortly after the active edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [4:0] r, input logic [2:0] rdy);
      idle();
      iss_wen  = 1'b1;
      iss_wreg = r;
      iss_rdy  = rdy;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("rst_stall", 32'(stall), 32'h0);
      check_eq("rst_refresh", 32'(refresh), 32'h0);
      check_eq("rst_hazard", 32'(id_hazard), 32'h0);
      check_eq("rst_ack", 32'(flush_ack), 32'h0);
      check_eq("rst_drop", 32'(inst_drop), 32'h0);

      // EC busy holds everything upstream and bubbles into WB.
      stg_busy = 5'b01000;
      #1;
      check_eq("ecbusy_stall", 32'(stall), 32'h7);
      check_eq("ecbusy_refresh", 32'(refresh), 32'h8);

      // Load r4 ready at stage 4: hazard for two cycles.
      tick(); issue(5'd4, 3'd4);
      tick(); idle(); id_rs_ren = 1'b1; id_rs = 5'd4; #1;
      check_eq("ld_haz_c1", 32'(id_hazard), 32'h1);
      check_eq("ld_ref1_c1", 32'(refresh[1]), 32'h1);
      tick(); #1;
      check_eq("ld_haz_c2", 32'(id_hazard), 32'h1);
      check_eq("ld_ref1_c2", 32'(refresh[1]), 32'h1);
      tick(); #1;
      check_eq("ld_haz_gone", 32'(id_hazard), 32'h0);

      // Same load with EC busy for 3 cycles while the load sits in EC.
      tick(); issue(5'd4, 3'd4);
      tick(); idle(); id_rs_ren = 1'b1; id_rs = 5'd4; #1;
      check_eq("ecw_haz0", 32'(id_hazard), 32'h1);
      for (int c = 0; c < 3; c++) begin
         tick(); stg_busy = 5'b01000; #1;
         check_eq($sformatf("ecw_haz_busy%0d", c), 32'(id_hazard), 32'h1);
      end
      tick(); stg_busy = 5'b00000; #1;
      check_eq("ecw_haz_release", 32'(id_hazard), 32'h1);
      tick(); #1;
      check_eq("ecw_haz_gone", 32'(id_hazard), 32'h0);

      // Flush to stage 3 waits for WB.
      tick(); idle(); stg_busy = 5'b10000; flush_req = 1'b1; flush_stg = 3'd3; #1;
      check_eq("fl3_wait_ack", 32'(flush_ack), 32'h0);
      check_eq("fl3_wait_refresh", 32'(refresh), 32'h0);
      tick(); flush_req = 1'b0; #1;
      check_eq("fl3_pend_ack", 32'(flush_ack), 32'h0);
      tick(); stg_busy = 5'b00000; #1;
      check_eq("fl3_ack", 32'(flush_ack), 32'h1);
      check_eq("fl3_refresh", 32'(refresh), 32'hf);
      check_eq("fl3_stall", 32'(stall), 32'h0);
      tick(); #1;
      check_eq("fl3_cleared", 32'(flush_ack), 32'h0);

      // Flush at stage 2 kills r7 (pos 2), keeps r9 (pos 3).
      tick(); issue(5'd9, 3'd5);
      tick(); issue(5'd7, 3'd5);
      tick(); idle(); flush_req = 1'b1; flush_stg = 3'd2; #1;
      check_eq("fl2_ack", 32'(flush_ack), 32'h1);
      check_eq("fl2_refresh", 32'(refresh), 32'h7);
      tick(); idle(); id_rs_ren = 1'b1; id_rs = 5'd7; #1;
      check_eq("fl2_r7_killed", 32'(id_hazard), 32'h0);
      id_rt_ren = 1'b1; id_rt = 5'd9; #1;
      check_eq("fl2_r9_kept", 32'(id_hazard), 32'h1);
      tick(); idle();
      tick();

      // Reissue r5 in the cycle the old r5 entry clears.
      issue(5'd5, 3'd3);
      tick(); issue(5'd5, 3'd4);
      tick(); idle(); id_rs_ren = 1'b1; id_rs = 5'd5; #1;
      check_eq("r5_reissue", 32'(id_hazard), 32'h1);
      tick(); tick(); idle();

      // Two fetches, flush, two stale responses, then a fresh one.
      tick(); inst_req = 1'b1; inst_addr_ok = 1'b1;
      tick();
      tick(); idle(); flush_req = 1'b1; flush_stg = 3'd0; #1;
      check_eq("fetch_flush_ack", 32'(flush_ack), 32'h1);
      tick(); idle(); inst_data_ok = 1'b1; #1;
      check_eq("drop_1", 32'(inst_drop), 32'h1);
      tick(); #1;
      check_eq("drop_2", 32'(inst_drop), 32'h1);
      tick(); idle(); inst_req = 1'b1; inst_addr_ok = 1'b1; #1;
      check_eq("drop_idle", 32'(inst_drop), 32'h0);
      tick(); idle(); inst_data_ok = 1'b1; #1;
      check_eq("drop_3rd", 32'(inst_drop), 32'h0);

      // Response in the flush_ack cycle belongs to the old stream.
      tick(); idle(); inst_req = 1'b1; inst_addr_ok = 1'b1;
      tick(); idle(); flush_req = 1'b1; inst_data_ok = 1'b1; #1;
      check_eq("same_cyc_ack", 32'(flush_ack), 32'h1);
      check_eq("same_cyc_drop", 32'(inst_drop), 32'h0);
      tick(); idle(); inst_req = 1'b1; inst_addr_ok = 1'b1;
      tick(); idle(); inst_data_ok = 1'b1; #1;
      check_eq("same_cyc_after", 32'(inst_drop), 32'h0);

      // Reset in the middle of a pending flush with a live entry.
      tick(); issue(5'd6, 3'd5);
      tick(); idle(); stg_busy = 5'b10000; flush_req = 1'b1; flush_stg = 3'd3; #1;
      check_eq("mrst_wait_ack", 32'(flush_ack), 32'h0);
      tick(); flush_req = 1'b0;
      #1 rst = 1'b1;
      idle(); id_rs_ren = 1'b1; id_rs = 5'd6;
      #1;
      check_eq("mrst_stall", 32'(stall), 32'h0);
      check_eq("mrst_refresh", 32'(refresh), 32'h0);
      check_eq("mrst_ack", 32'(flush_ack), 32'h0);
      check_eq("mrst_hazard", 32'(id_hazard), 32'h0);
      check_eq("mrst_drop", 32'(inst_drop), 32'h0);
      tick(); rst = 1'b0; #1;
      check_eq("mrst_post_ack", 32'(flush_ack), 32'h0);
      check_eq("mrst_post_hazard", 32'(id_hazard), 32'h0);
      check_eq("mrst_post_refresh", 32'(refresh), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
